// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed FIR engine.
package fir_pkg;

    localparam int IX_CLEAR = 0;
    localparam int IX_IDLE  = 1;
    localparam int IX_MAC   = 2;
    localparam int IX_ROUND = 3;
    localparam int IX_OUT   = 4;

    typedef enum logic [4:0] {
        S_CLEAR = 5'b00001,
        S_IDLE  = 5'b00010,
        S_MAC   = 5'b00100,
        S_ROUND = 5'b01000,
        S_OUT   = 5'b10000
    } state_e;

    function automatic int acc_width(input int width, input int taps);
        return 2 * width + $clog2(taps);
    endfunction

    // Round half up, then clamp into the signed output range.
    function automatic logic signed [63:0] sat_round(
        input logic signed [63:0] acc,
        input int                 width
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (width - 2))) >>> (width - 1);
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_mac_engine_if.sv
// Sample, coefficient and output handshake bundle of the FIR engine.
interface fir_mac_engine_if #(
    parameter int WIDTH = 16,
    parameter int TAPS  = 8,
    parameter int CH_W  = 1
);
    localparam int KW = $clog2(TAPS);

    logic                    coeff_we;
    logic [KW-1:0]           coeff_addr;
    logic signed [WIDTH-1:0] coeff_data;
    logic                    coeff_busy;
    logic                    rts;
    logic [CH_W-1:0]         aud_ch;
    logic signed [WIDTH-1:0] aud_in;
    logic                    rtr;
    logic                    out_rts;
    logic                    out_rtr;
    logic [CH_W-1:0]         out_ch;
    logic signed [WIDTH-1:0] aud_out;

    modport master (
        output coeff_we, coeff_addr, coeff_data,
        output rts, aud_ch, aud_in, out_rtr,
        input  coeff_busy, rtr, out_rts, out_ch, aud_out
    );

    modport slave (
        input  coeff_we, coeff_addr, coeff_data,
        input  rts, aud_ch, aud_in, out_rtr,
        output coeff_busy, rtr, out_rts, out_ch, aud_out
    );

endinterface

// File: rtl/fir_history_ram.sv
// Per-channel sample history: one write port, one registered read port.
module fir_history_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [AW-1:0]           waddr_i,
    input  logic signed [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]           raddr_i,
    output logic signed [WIDTH-1:0] rdata_o
);
    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic signed [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_mac_engine.sv
// Multi-channel FIR filter sharing one MAC across all taps and channels.
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAPS  = 8,
    parameter int NCH   = 2,
    parameter int CH_W  = 1
) (
    input logic             clk,
    input logic             rst,
    fir_mac_engine_if.slave bus
);
    localparam int KW    = $clog2(TAPS);
    localparam int DEPTH = NCH * TAPS;
    localparam int AW    = $clog2(DEPTH);
    localparam int ACC_W = acc_width(WIDTH, TAPS);
    localparam int PW    = 2 * WIDTH;

    state_e                  st_q, st_d;
    logic [AW-1:0]           clr_q, clr_d;
    logic [KW-1:0]           k_q, k_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic signed [WIDTH-1:0] x0_q, x0_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] out_q, out_d;
    logic [CH_W-1:0]         och_q, och_d;
    logic [KW-1:0]           ptr_q [NCH];
    logic signed [WIDTH-1:0] coef_q [TAPS];

    logic                    adv;
    logic                    rtr_w;
    logic                    busy_w;
    logic                    ch_ok;
    logic [CH_W-1:0]         in_ch;
    logic                    accept;
    logic                    coef_we;
    logic                    ram_we;
    logic [AW-1:0]           ram_waddr;
    logic signed [WIDTH-1:0] ram_wdata;
    logic [AW-1:0]           ram_raddr;
    logic signed [WIDTH-1:0] ram_rdata;
    logic signed [WIDTH-1:0] mac_x;
    logic signed [PW-1:0]    prod;
    logic [CH_W-1:0]         rd_ch;
    int                      rd_off;
    int                      rd_i;

    assign ch_ok   = int'(bus.aud_ch) < NCH;
    assign in_ch   = ch_ok ? bus.aud_ch : '0;
    assign accept  = !rst && st_q[IX_IDLE] && bus.rts;
    assign coef_we = !rst && st_q[IX_IDLE] && bus.coeff_we
                     && (int'(bus.coeff_addr) < TAPS);

    assign ram_we    = st_q[IX_CLEAR] || (accept && ch_ok);
    assign ram_waddr = st_q[IX_CLEAR] ? clr_q
                     : AW'(int'(in_ch) * TAPS + int'(ptr_q[in_ch]));
    assign ram_wdata = st_q[IX_CLEAR] ? '0 : bus.aud_in;

    // Reads run one tap ahead; tap 0 comes from the latched input sample.
    always_comb begin
        rd_ch  = st_q[IX_MAC] ? ch_q : in_ch;
        rd_off = st_q[IX_MAC] ? int'(k_q) + 1 : 1;
        rd_i   = int'(ptr_q[rd_ch]) - rd_off;
        if (rd_i < 0) begin
            rd_i = rd_i + TAPS;
        end
        ram_raddr = AW'(int'(rd_ch) * TAPS + rd_i);
    end

    assign mac_x = (k_q == '0) ? x0_q : ram_rdata;
    assign prod  = PW'(mac_x) * PW'(coef_q[k_q]);

    fir_history_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_hist (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        st_d   = st_q;
        clr_d  = clr_q;
        k_d    = k_q;
        ch_d   = ch_q;
        x0_d   = x0_q;
        acc_d  = acc_q;
        out_d  = out_q;
        och_d  = och_q;
        adv    = 1'b0;
        rtr_w  = 1'b0;
        busy_w = 1'b1;
        unique case (1'b1)
            st_q[IX_CLEAR]: begin
                clr_d = clr_q + AW'(1);
                if (clr_q == AW'(DEPTH - 1)) begin
                    clr_d = '0;
                    st_d  = S_IDLE;
                end
            end
            st_q[IX_IDLE]: begin
                rtr_w  = 1'b1;
                busy_w = 1'b0;
                if (bus.rts && ch_ok) begin
                    st_d  = S_MAC;
                    ch_d  = in_ch;
                    x0_d  = bus.aud_in;
                    acc_d = '0;
                    k_d   = '0;
                end
            end
            st_q[IX_MAC]: begin
                acc_d = acc_q + ACC_W'(prod);
                k_d   = k_q + KW'(1);
                if (k_q == KW'(TAPS - 1)) begin
                    k_d  = '0;
                    st_d = S_ROUND;
                end
            end
            st_q[IX_ROUND]: begin
                out_d = WIDTH'(sat_round(64'(acc_q), WIDTH));
                och_d = ch_q;
                adv   = 1'b1;
                st_d  = S_OUT;
            end
            st_q[IX_OUT]: begin
                if (bus.out_rtr) begin
                    st_d = S_IDLE;
                end
            end
            default: begin
                st_d = S_CLEAR;
            end
        endcase
        if (rst) begin
            rtr_w  = 1'b0;
            busy_w = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= S_CLEAR;
            clr_q <= '0;
            k_q   <= '0;
            ch_q  <= '0;
            x0_q  <= '0;
            acc_q <= '0;
            out_q <= '0;
            och_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            st_q  <= st_d;
            clr_q <= clr_d;
            k_q   <= k_d;
            ch_q  <= ch_d;
            x0_q  <= x0_d;
            acc_q <= acc_d;
            out_q <= out_d;
            och_q <= och_d;
            if (adv) begin
                ptr_q[ch_q] <= (ptr_q[ch_q] == KW'(TAPS - 1))
                               ? '0 : ptr_q[ch_q] + KW'(1);
            end
        end
    end

    // Coefficients survive reset so a re-clear keeps the loaded filter.
    always_ff @(posedge clk) begin
        if (coef_we) begin
            coef_q[bus.coeff_addr] <= bus.coeff_data;
        end
    end

    assign bus.rtr        = rtr_w;
    assign bus.coeff_busy = busy_w;
    assign bus.out_rts    = st_q[IX_OUT];
    assign bus.out_ch     = och_q;
    assign bus.aud_out    = out_q;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine against a queue-based FIR model.
module tb_fir_mac_engine;

    localparam int W      = 16;
    localparam int TAPS   = 8;
    localparam int NCH    = 2;
    localparam int CH_W   = 1;
    localparam int KW     = 3;
    localparam int BUDGET = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_mac_engine_if #(.WIDTH(W), .TAPS(TAPS), .CH_W(CH_W)) bus ();

    fir_mac_engine #(
        .WIDTH (W),
        .TAPS  (TAPS),
        .NCH   (NCH),
        .CH_W  (CH_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    longint h_m [TAPS];
    longint hist [NCH][$];

    function automatic void model_clear();
        for (int c = 0; c < NCH; c++) begin
            hist[c].delete();
            for (int k = 0; k < TAPS; k++) hist[c].push_back(0);
        end
    endfunction

    // y[n] = sum h[k]*x[n-k], rounded half up and clamped.
    function automatic logic signed [W-1:0] model_step(int ch, longint x);
        longint acc = 0;
        longint r;
        hist[ch].push_front(x);
        void'(hist[ch].pop_back());
        for (int k = 0; k < TAPS; k++) acc += h_m[k] * hist[ch][k];
        r = (acc + (longint'(1) << (W - 2))) >>> (W - 1);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r[W-1:0];
    endfunction

    task automatic write_coeff(input int k, input logic signed [W-1:0] v);
        bus.coeff_we   = 1'b1;
        bus.coeff_addr = KW'(k);
        bus.coeff_data = v;
        h_m[k]         = longint'(v);
        @(negedge clk);
        bus.coeff_we   = 1'b0;
    endtask

    // wmode 1: coeff write on the accept cycle; 2: write during MAC.
    task automatic run_sample(
        input  int                  ch,
        input  logic signed [W-1:0] x,
        input  int                  wmode,
        input  int                  wk,
        input  logic signed [W-1:0] wv,
        output logic signed [W-1:0] y,
        output int                  ych,
        output int                  lat,
        output int                  tacc,
        output bit                  busy_seen,
        output bit                  ok
    );
        int n = 0;
        ok = 1'b1; lat = 0; tacc = 0; busy_seen = 1'b0; y = '0; ych = 0;
        bus.rts = 1'b1; bus.aud_ch = CH_W'(ch); bus.aud_in = x;
        while (!bus.rtr && n < BUDGET) begin @(negedge clk); n++; end
        if (!bus.rtr) begin bus.rts = 1'b0; ok = 1'b0; return; end
        if (wmode == 1) begin
            bus.coeff_we = 1'b1; bus.coeff_addr = KW'(wk); bus.coeff_data = wv;
        end
        tacc = cyc;
        @(negedge clk);
        bus.rts = 1'b0; bus.coeff_we = 1'b0;
        lat = 1;
        if (wmode == 2) begin
            bus.coeff_we = 1'b1; bus.coeff_addr = KW'(wk); bus.coeff_data = wv;
            busy_seen = bus.coeff_busy;
            @(negedge clk);
            bus.coeff_we = 1'b0;
            lat++;
        end
        while (!bus.out_rts && lat < BUDGET) begin @(negedge clk); lat++; end
        if (!bus.out_rts) begin ok = 1'b0; return; end
        y = bus.aud_out; ych = int'(bus.out_ch);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rtr !== 1'b0 || bus.out_rts !== 1'b0 || bus.coeff_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl rtr=%b out_rts=%b busy=%b want 0 0 1",
                     bus.rtr, bus.out_rts, bus.coeff_busy);
        end
        checks++;
        if (bus.aud_out !== '0 || bus.out_ch !== '0) begin
            errors++;
            $display("FAIL reset_data aud_out=%h out_ch=%0d want 0 0", bus.aud_out, bus.out_ch);
        end
        rst = 1'b0;
        while (!bus.rtr && n < BUDGET) begin n++; @(negedge clk); end
        checks++;
        if (n != NCH * TAPS) begin
            errors++;
            $display("FAIL clear_len got %0d want %0d", n, NCH * TAPS);
        end
        checks++;
        if (bus.coeff_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got %b want 0", bus.coeff_busy);
        end
        model_clear();
    endtask

    task automatic test_impulse();
        logic signed [W-1:0] hv [TAPS];
        logic signed [W-1:0] y, exp;
        int ych, lat, tacc;
        bit bs, ok;
        hv = '{16'sh4000, 16'sh2000, 16'sh0, 16'sh0, 16'sh0, 16'sh0, 16'sh0, 16'sh1000};
        for (int k = 0; k < TAPS; k++) write_coeff(k, hv[k]);
        for (int i = 0; i < TAPS; i++) begin
            exp = model_step(0, (i == 0) ? 32767 : 0);
            run_sample(0, (i == 0) ? 16'sh7fff : 16'sh0, 0, 0, 0, y, ych, lat, tacc, bs, ok);
            checks++;
            if (!ok || y !== exp || ych != 0) begin
                errors++;
                $display("FAIL impulse[%0d] got %h ch%0d ok%0d want %h ch0", i, y, ych, ok, exp);
            end
            if (i == 0) begin
                checks++;
                if (lat != TAPS + 2) begin
                    errors++;
                    $display("FAIL latency got %0d want %0d", lat, TAPS + 2);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [W-1:0] y, exp, x;
        int ych, lat, tacc;
        bit bs, ok;
        for (int k = 0; k < TAPS; k++) write_coeff(k, 16'sh7fff);
        for (int i = 0; i < 2 * TAPS; i++) begin
            x = (i < TAPS) ? 16'sh7fff : 16'sh8000;
            exp = model_step(0, longint'(x));
            run_sample(0, x, 0, 0, 0, y, ych, lat, tacc, bs, ok);
            checks++;
            if (!ok || y !== exp) begin
                errors++;
                $display("FAIL saturate[%0d] got %h want %h", i, y, exp);
            end
        end
    endtask

    task automatic test_channels();
        logic signed [W-1:0] y, exp, x;
        int ych, lat, tacc, ch;
        bit bs, ok;
        for (int i = 0; i < 2 * TAPS; i++) begin
            ch = i % 2;
            x = (ch == 0) ? 16'sh1000 : 16'sh0;
            exp = model_step(ch, longint'(x));
            run_sample(ch, x, 0, 0, 0, y, ych, lat, tacc, bs, ok);
            checks++;
            if (!ok || y !== exp || ych != ch) begin
                errors++;
                $display("FAIL chan[%0d] got %h ch%0d want %h ch%0d", i, y, ych, exp, ch);
            end
        end
    endtask

    task automatic test_backpressure();
        logic signed [W-1:0] y0, exp, exp2, x2, y;
        logic [CH_W-1:0] c0;
        int n = 0;
        int ych, lat, tacc;
        bit bs, ok;
        exp = model_step(1, -1234);
        bus.out_rtr = 1'b0;
        bus.rts = 1'b1; bus.aud_ch = 1'b1; bus.aud_in = -16'sd1234;
        while (!bus.rtr && n < BUDGET) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.rts = 1'b0;
        n = 0;
        while (!bus.out_rts && n < BUDGET) begin @(negedge clk); n++; end
        checks++;
        if (bus.out_rts !== 1'b1 || bus.aud_out !== exp || bus.out_ch !== 1'b1) begin
            errors++;
            $display("FAIL bp_first got %h ch%0d want %h ch1", bus.aud_out, bus.out_ch, exp);
        end
        y0 = bus.aud_out; c0 = bus.out_ch;
        x2 = W'($urandom);
        bus.rts = 1'b1; bus.aud_ch = 1'b0; bus.aud_in = x2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus.aud_out !== y0 || bus.out_ch !== c0 || bus.rtr !== 1'b0 || bus.out_rts !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d] got %h ch%0d rtr%b ors%b want %h ch%0d rtr0 ors1",
                         i, bus.aud_out, bus.out_ch, bus.rtr, bus.out_rts, y0, c0);
            end
        end
        bus.out_rtr = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_rts !== 1'b0 || bus.rtr !== 1'b1) begin
            errors++;
            $display("FAIL bp_release ors=%b rtr=%b want 0 1", bus.out_rts, bus.rtr);
        end
        exp2 = model_step(0, longint'(x2));
        run_sample(0, x2, 0, 0, 0, y, ych, lat, tacc, bs, ok);
        checks++;
        if (!ok || y !== exp2 || ych != 0) begin
            errors++;
            $display("FAIL bp_pending got %h ch%0d want %h ch0", y, ych, exp2);
        end
    endtask

    task automatic test_coeff_busy();
        logic signed [W-1:0] y, exp;
        int ych, lat, tacc;
        bit bs, ok;
        write_coeff(0, 16'sh1000);
        exp = model_step(0, 5000);
        run_sample(0, 16'sd5000, 2, 0, 16'sh7fff, y, ych, lat, tacc, bs, ok);
        checks++;
        if (bs !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_mac got %b want 1", bs);
        end
        checks++;
        if (!ok || y !== exp) begin
            errors++;
            $display("FAIL busy_drop got %h want %h", y, exp);
        end
        exp = model_step(1, 3000);
        run_sample(1, 16'sd3000, 0, 0, 0, y, ych, lat, tacc, bs, ok);
        checks++;
        if (!ok || y !== exp) begin
            errors++;
            $display("FAIL busy_keep got %h want %h", y, exp);
        end
        h_m[0] = 32767;
        exp = model_step(0, -7000);
        run_sample(0, -16'sd7000, 1, 0, 16'sh7fff, y, ych, lat, tacc, bs, ok);
        checks++;
        if (!ok || y !== exp) begin
            errors++;
            $display("FAIL accept_write got %h want %h", y, exp);
        end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [W-1:0] y, exp, x;
        int n = 0;
        int ych, lat, tacc;
        bit bs, ok, seen;
        bus.rts = 1'b1; bus.aud_ch = 1'b0; bus.aud_in = 16'sh2345;
        while (!bus.rtr && n < BUDGET) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.rts = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_rts !== 1'b0 || bus.rtr !== 1'b0 || bus.coeff_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst ors=%b rtr=%b busy=%b want 0 0 1",
                     bus.out_rts, bus.rtr, bus.coeff_busy);
        end
        rst = 1'b0;
        n = 0; seen = 1'b0;
        while (!bus.rtr && n < BUDGET) begin
            if (bus.out_rts) seen = 1'b1;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != NCH * TAPS || seen) begin
            errors++;
            $display("FAIL mid_clear len=%0d out_seen=%0d want %0d 0", n, seen, NCH * TAPS);
        end
        model_clear();
        for (int c = 0; c < NCH; c++) begin
            x = W'($urandom);
            exp = model_step(c, longint'(x));
            run_sample(c, x, 0, 0, 0, y, ych, lat, tacc, bs, ok);
            checks++;
            if (!ok || y !== exp || ych != c) begin
                errors++;
                $display("FAIL post_rst[%0d] got %h want %h", c, y, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic signed [W-1:0] y, exp, x;
        int ych, lat, tacc, prev, ch;
        bit bs, ok;
        for (int k = 0; k < TAPS; k++) write_coeff(k, W'($urandom));
        prev = 0;
        for (int i = 0; i < 24; i++) begin
            ch = int'($urandom_range(0, NCH - 1));
            case ($urandom_range(0, 5))
                0: x = 16'sh7fff;
                1: x = 16'sh8000;
                default: x = W'($urandom);
            endcase
            exp = model_step(ch, longint'(x));
            run_sample(ch, x, 0, 0, 0, y, ych, lat, tacc, bs, ok);
            checks++;
            if (!ok || y !== exp || ych != ch) begin
                errors++;
                $display("FAIL b2b[%0d] got %h ch%0d want %h ch%0d", i, y, ych, exp, ch);
            end
            if (i > 0) begin
                checks++;
                if (tacc - prev != TAPS + 3) begin
                    errors++;
                    $display("FAIL b2b_rate[%0d] got %0d want %0d", i, tacc - prev, TAPS + 3);
                end
            end
            prev = tacc;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.coeff_we   = 1'b0;
        bus.coeff_addr = '0;
        bus.coeff_data = '0;
        bus.rts        = 1'b0;
        bus.aud_ch     = '0;
        bus.aud_in     = '0;
        bus.out_rtr    = 1'b1;
        for (int k = 0; k < TAPS; k++) h_m[k] = 0;
        @(negedge clk);
        test_reset();
        test_impulse();
        test_saturation();
        test_channels();
        test_backpressure();
        test_coeff_busy();
        test_reset_mid_mac();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
